// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enumeration and default width constants.
package alu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SHIFT_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor with carry-in and two's-complement overflow detection.
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic                    sub,
  input  logic                    cin,
  output logic signed [WIDTH-1:0] sum,
  output logic                    overflow
);

  logic signed [WIDTH+1:0] xe;
  logic signed [WIDTH+1:0] ye;
  logic signed [WIDTH+1:0] ce;
  logic signed [WIDTH+1:0] full;
  logic        [2:0]       top;

  // Two guard bits hold the exact signed result of x +/- y +/- cin.
  assign xe   = {{2{x[WIDTH-1]}}, x};
  assign ye   = {{2{y[WIDTH-1]}}, y};
  assign ce   = {{(WIDTH+1){1'b0}}, cin};
  assign full = sub ? (xe - ye - ce) : (xe + ye + ce);

  assign sum      = full[WIDTH-1:0];
  assign top      = full[WIDTH+1:WIDTH-1];
  assign overflow = ~((&top) | (~|top));

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU. Define ALU_CARRY_IN_EN to let carry_in feed ADD/SUB;
// otherwise carry_in is ignored.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int OPERATION = 3,
  parameter int SHIFT     = SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERATION-1:0] operation,
  input  logic [SHIFT-1:0]     shamt,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 carry_in,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow,
  output logic                 zero
);

  function automatic logic [WIDTH-1:0] shift_sra(input logic signed [WIDTH-1:0] a,
                                                 input logic [SHIFT-1:0] s);
    return a >>> s;
  endfunction

  alu_op_e                  op_p0;
  logic                     cin_eff;
  logic signed [WIDTH-1:0]  sum_p0;
  logic                     as_ovf_p0;
  logic        [WIDTH-1:0]  result_p0;
  logic                     overflow_p0;
  logic        [WIDTH-1:0]  result_p1;
  logic                     overflow_p1;
  logic                     zero_p1;

`ifdef ALU_CARRY_IN_EN
  assign cin_eff = carry_in;
`else
  logic unused_carry_in;
  assign cin_eff         = 1'b0;
  assign unused_carry_in = carry_in;
`endif

  assign op_p0 = alu_op_e'(operation);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x        ($signed(x)),
    .y        ($signed(y)),
    .sub      (op_p0 == OP_SUB),
    .cin      (cin_eff),
    .sum      (sum_p0),
    .overflow (as_ovf_p0)
  );

  always_comb begin
    result_p0   = '0;
    overflow_p0 = 1'b0;
    case (op_p0)
      OP_ADD, OP_SUB: begin
        result_p0   = sum_p0;
        overflow_p0 = as_ovf_p0;
      end
      OP_AND:  result_p0 = x & y;
      OP_OR:   result_p0 = x | y;
      OP_XOR:  result_p0 = x ^ y;
      OP_SLL:  result_p0 = x << shamt;
      OP_SRL:  result_p0 = x >> shamt;
      OP_SRA:  result_p0 = shift_sra($signed(x), shamt);
      default: result_p0 = '0;
    endcase
  end

  // Stage p0 -> p1: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1   <= '0;
      overflow_p1 <= 1'b0;
      zero_p1     <= 1'b1;
    end else begin
      result_p1   <= result_p0;
      overflow_p1 <= overflow_p0;
      zero_p1     <= (result_p0 == '0);
    end
  end

  assign result   = result_p1;
  assign overflow = overflow_p1;
  assign zero     = zero_p1;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the registered ALU against an integer reference model.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] operation;
  logic [2:0] shamt;
  logic [7:0] x;
  logic [7:0] y;
  logic       carry_in;
  logic [7:0] result;
  logic       overflow;
  logic       zero;

  int total  = 0;
  int passed = 0;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .shamt     (shamt),
    .x         (x),
    .y         (y),
    .carry_in  (carry_in),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] s, input logic c);
    rst = r; operation = op; x = a; y = b; shamt = s; carry_in = c;
    @(posedge clk);
    #1;
  endtask

  // Reference computed with plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [2:0] s,
                                input logic c, output logic [7:0] r, output logic v);
    int sa, sb, ce, t;
    sa = (a > 8'd127) ? int'(a) - 256 : int'(a);
    sb = (b > 8'd127) ? int'(b) - 256 : int'(b);
`ifdef ALU_CARRY_IN_EN
    ce = int'(c);
`else
    ce = 0;
`endif
    v = 1'b0;
    t = 0;
    case (op)
      3'd0: begin t = sa + sb + ce; v = (t > 127) || (t < -128); end
      3'd1: begin t = sa - sb - ce; v = (t > 127) || (t < -128); end
      3'd2: t = int'(a & b);
      3'd3: t = int'(a | b);
      3'd4: t = int'(a ^ b);
      3'd5: t = int'(a) * (1 << s);
      3'd6: t = int'(a) / (1 << s);
      default: t = sa >>> s;
    endcase
    r = t[7:0];
  endfunction

  logic [7:0] er;
  logic       ev;
  logic [7:0] ra, rb;
  logic [2:0] rop, rs;
  logic       rc;

  initial begin
    // Reset state
    step(1'b1, 3'd0, 8'h12, 8'h34, 3'd1, 1'b1);
    chk("rst_result", result, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);
    chk("rst_zero", {7'd0, zero}, 8'h01);

    // ADD FF+FF with carry_in
    step(1'b0, 3'd0, 8'hFF, 8'hFF, 3'd0, 1'b1);
`ifdef ALU_CARRY_IN_EN
    chk("add_cin_result", result, 8'hFF);
`else
    chk("add_cin_result", result, 8'hFE);
`endif
    chk("add_cin_ovf", {7'd0, overflow}, 8'h00);
    chk("add_cin_zero", {7'd0, zero}, 8'h00);

    // Signed overflow on ADD and SUB
    step(1'b0, 3'd0, 8'h7F, 8'h01, 3'd0, 1'b0);
    chk("add_ovf_result", result, 8'h80);
    chk("add_ovf_flag", {7'd0, overflow}, 8'h01);
    step(1'b0, 3'd1, 8'h80, 8'h01, 3'd0, 1'b0);
    chk("sub_ovf_result", result, 8'h7F);
    chk("sub_ovf_flag", {7'd0, overflow}, 8'h01);

    // Shifts
    step(1'b0, 3'd5, 8'hFF, 8'h55, 3'd4, 1'b1);
    chk("sll_result", result, 8'hF0);
    chk("sll_ovf", {7'd0, overflow}, 8'h00);
    step(1'b0, 3'd6, 8'hFF, 8'h55, 3'd4, 1'b1);
    chk("srl_result", result, 8'h0F);
    chk("srl_ovf", {7'd0, overflow}, 8'h00);
    step(1'b0, 3'd7, 8'h80, 8'h55, 3'd4, 1'b1);
    chk("sra_result", result, 8'hF8);
    chk("sra_ovf", {7'd0, overflow}, 8'h00);
    step(1'b0, 3'd7, 8'h70, 8'h00, 3'd4, 1'b0);
    chk("sra_pos_result", result, 8'h07);

    // Bitwise ops and zero flag
    step(1'b0, 3'd2, 8'hF0, 8'h0F, 3'd0, 1'b0);
    chk("and_result", result, 8'h00);
    chk("and_zero", {7'd0, zero}, 8'h01);
    step(1'b0, 3'd3, 8'hF0, 8'h0F, 3'd0, 1'b0);
    chk("or_result", result, 8'hFF);
    chk("or_zero", {7'd0, zero}, 8'h00);
    step(1'b0, 3'd4, 8'hF0, 8'h0F, 3'd0, 1'b0);
    chk("xor_result", result, 8'hFF);
    step(1'b0, 3'd4, 8'hAA, 8'hAA, 3'd0, 1'b0);
    chk("xor_same_zero", {7'd0, zero}, 8'h01);
    step(1'b0, 3'd1, 8'hAA, 8'hAA, 3'd0, 1'b0);
    chk("sub_eq_result", result, 8'h00);
    chk("sub_eq_zero", {7'd0, zero}, 8'h01);

    // SUB with borrow in
    step(1'b0, 3'd1, 8'h05, 8'h03, 3'd0, 1'b1);
`ifdef ALU_CARRY_IN_EN
    chk("sub_cin_result", result, 8'h01);
`else
    chk("sub_cin_result", result, 8'h02);
`endif

    // Mid-stream reset
    step(1'b0, 3'd0, 8'h10, 8'h20, 3'd0, 1'b0);
    chk("pre_rst_result", result, 8'h30);
    step(1'b1, 3'd3, 8'hC3, 8'h5A, 3'd2, 1'b1);
    chk("mid_rst_result", result, 8'h00);
    chk("mid_rst_ovf", {7'd0, overflow}, 8'h00);
    chk("mid_rst_zero", {7'd0, zero}, 8'h01);
    step(1'b0, 3'd0, 8'h40, 8'h40, 3'd0, 1'b0);
    chk("post_rst_result", result, 8'h80);
    chk("post_rst_ovf", {7'd0, overflow}, 8'h01);
    chk("post_rst_zero", {7'd0, zero}, 8'h00);

    // Random stream against the reference model
    for (int i = 0; i < 1200; i++) begin
      rop = 3'($urandom_range(7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rs  = 3'($urandom_range(7));
      rc  = 1'($urandom);
      model(rop, ra, rb, rs, rc, er, ev);
      step(1'b0, rop, ra, rb, rs, rc);
      chk("rand_result", result, er);
      chk("rand_ovf", {7'd0, overflow}, {7'd0, ev});
      chk("rand_zero", {7'd0, zero}, {7'd0, (er == 8'h00)});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of x, y and result.
REQ-002 SHALL have parameter OPERATION, default 3, opcode width.
REQ-003 SHALL have parameter SHIFT, default 3, shamt width; SHIFT = clog2(WIDTH).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port operation, input, OPERATION bits, opcode.
REQ-007 SHALL have port shamt, input, SHIFT bits, shift amount, unsigned.
REQ-008 SHALL have port x, input, WIDTH bits, operand A.
REQ-009 SHALL have port y, input, WIDTH bits, operand B.
REQ-010 SHALL have port carry_in, input, 1 bit, carry/borrow into ADD/SUB.
REQ-011 SHALL have port result, output, WIDTH bits, registered result.
REQ-012 SHALL have port overflow, output, 1 bit, registered signed overflow flag.
REQ-013 SHALL have port zero, output, 1 bit, registered flag, 1 when result is all zeros.

Function
REQ-014 SHALL sample operation, shamt, x, y and carry_in on each rising clk edge and present result, overflow and zero after that edge; latency 1 cycle, no handshake, new operation every cycle.
REQ-015 SHALL decode the opcode as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
REQ-016 ADD SHALL give result = (x + y + cin_eff) mod 2^WIDTH; SUB SHALL give (x - y - cin_eff) mod 2^WIDTH; cin_eff per REQ-024/025.
REQ-017 AND, OR and XOR SHALL be bitwise on x and y.
REQ-018 SLL SHALL be x shifted left by shamt, zero-filled; SRL SHALL be a logical right shift, zero-filled; SRA SHALL be an arithmetic right shift, sign-filled from x[WIDTH-1]; y is ignored for shifts.
REQ-019 overflow SHALL be 1 only for ADD/SUB when the true signed (two's-complement) result of the full expression, including cin_eff, is outside the WIDTH-bit signed range; otherwise 0.
REQ-020 zero SHALL equal 1 exactly when the registered result is all zeros, for every opcode.
REQ-021 Wrap-around SHALL be silent; no carry-out port.

Reset
REQ-022 When rst is 1 at a rising edge, result SHALL become 0, overflow 0 and zero 1, regardless of other inputs.
REQ-023 When rst asserts mid-stream, the pending operation SHALL be discarded; the first post-reset result SHALL be from the inputs sampled on the first edge with rst at 0.

Configuration
REQ-024 With macro ALU_CARRY_IN_EN defined, cin_eff SHALL equal carry_in.
REQ-025 With ALU_CARRY_IN_EN undefined, cin_eff SHALL be 0 and carry_in SHALL be ignored; the port SHALL still exist.

Structure
REQ-026 Package alu_pkg SHALL hold the opcode enumeration (ADD through SRA) and default WIDTH/SHIFT constants.
REQ-027 A combinational sub-module alu_addsub SHALL compute the ADD/SUB sum and signed overflow; all other logic and the output registers SHALL be in alu.

Verification
REQ-028 With ALU_CARRY_IN_EN defined, x=FF, y=FF, carry_in=1, ADD SHALL give result FF, overflow 0 and zero 0; with the macro undefined the same stimulus SHALL give result FE.
REQ-029 x=7F, y=01, carry_in=0, ADD SHALL give result 80 with overflow 1; x=80, y=01, SUB SHALL give result 7F with overflow 1.
REQ-030 x=FF, shamt=4 SHALL give F0 for SLL and 0F for SRL; x=80, shamt=4, SRA SHALL give F8; overflow SHALL be 0 in all three cases.
REQ-031 x=F0, y=0F SHALL give AND 00 with zero 1, OR FF with zero 0 and XOR FF; x=y=AA, SUB with carry_in=0 SHALL give 00 with zero 1.
REQ-032 rst=1 for one edge during a stream of random operations SHALL give result 00, overflow 0 and zero 1 on that edge; the next edge SHALL give the correct result for the inputs applied then.
REQ-033 Random x, y, shamt and carry_in across all 8 opcodes for at least 1000 cycles SHALL match a reference model with 1-cycle latency, for both settings of ALU_CARRY_IN_EN.
